// File: rtl/qpsk_mod_stream.sv
// Streaming QPSK modulator: maps 2-bit symbols onto a supplied cos/sin LO for SPS samples each.
// Define QPSK_MOD_OFFSET_EN to build offset-QPSK (Q bit delayed by SPS/2 samples).
module qpsk_mod_stream #(
  parameter int W   = 9,
  parameter int SPS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] lo_cos,
  input  logic signed [W-1:0] lo_sin,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_bits,
  output logic signed [W:0]   out_sample,
  output logic                out_valid,
  output logic                underrun
);

  localparam int CW = $clog2(SPS);
  localparam logic [CW-1:0] LAST = CW'(SPS - 1);
  localparam logic [CW-1:0] HALF = CW'(SPS / 2 - 1);
  localparam logic signed [W:0] SAT_MAX = {1'b0, {W{1'b1}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_nxt;
  logic            hold_full;
  logic [1:0]      hold_bits;
  logic            cur_i, cur_q, q_used;
  logic [CW-1:0]   cnt;
  logic            last, xfer;
  logic            load_hold, load_in, underrun_nxt;

  // Handshake: a symbol transfers on a rising edge with in_valid && in_ready;
  // in_ready depends only on the holding register, never on in_valid.
  assign in_ready = ~hold_full;
  assign xfer     = in_valid & in_ready;
  assign last     = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    load_hold    = 1'b0;
    load_in      = 1'b0;
    underrun_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) begin
          load_hold = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last) begin
          // A symbol arriving on the final sample edge bypasses the holding register.
          if (hold_full)  load_hold = 1'b1;
          else if (xfer)  load_in   = 1'b1;
          else begin
            state_nxt    = IDLE;
            underrun_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_bits <= 2'b00;
      cur_i     <= 1'b0;
      cur_q     <= 1'b0;
      cnt       <= '0;
      underrun  <= 1'b0;
    end else begin
      if (xfer && !load_in) begin
        hold_full <= 1'b1;
        hold_bits <= in_bits;
      end else if (load_hold) begin
        hold_full <= 1'b0;
      end
      if (load_hold) begin
        cur_i <= hold_bits[1];
        cur_q <= hold_bits[0];
      end else if (load_in) begin
        cur_i <= in_bits[1];
        cur_q <= in_bits[0];
      end
      if (state == RUN) cnt <= last ? '0 : cnt + 1'b1;
      else              cnt <= '0;
      underrun <= underrun_nxt;
    end
  end

`ifdef QPSK_MOD_OFFSET_EN
  logic q_eff;

  // Q switches after the first half of the symbol has been emitted.
  always_ff @(posedge clk) begin
    if (rst)                               q_eff <= 1'b0;
    else if (state == RUN && cnt == HALF)  q_eff <= cur_q;
  end
  assign q_used = q_eff;
`else
  assign q_used = cur_q;
`endif

  logic signed [W:0]   cos_x, sin_x, i_term, q_term, mod_sample;
  logic signed [W+1:0] sum;

  assign cos_x  = {lo_cos[W-1], lo_cos};
  assign sin_x  = {lo_sin[W-1], lo_sin};
  assign i_term = cur_i  ? cos_x : -cos_x;
  assign q_term = q_used ? sin_x : -sin_x;
  assign sum    = {i_term[W], i_term} + {q_term[W], q_term};
  // Only +2^W can overflow W+1 bits; the negative extreme is representable.
  assign mod_sample = (sum[W+1:W] == 2'b01) ? SAT_MAX : $signed(sum[W:0]);

  always_ff @(posedge clk) begin
    if (rst || state != RUN) begin
      out_sample <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_sample <= mod_sample;
      out_valid  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_qpsk_mod_stream.sv
// Bench for qpsk_mod_stream: symbol scoreboard plus a sample-level reference model.
module tb_qpsk_mod_stream;
  localparam int W   = 9;
  localparam int SPS = 4;
  localparam int MAXV = (1 << W) - 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic signed [W-1:0] lo_cos = '0;
  logic signed [W-1:0] lo_sin = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [1:0]          in_bits = 2'b00;
  logic signed [W:0]   out_sample;
  logic                out_valid;
  logic                underrun;

  qpsk_mod_stream #(.W(W), .SPS(SPS)) dut (
    .clk(clk), .rst(rst), .lo_cos(lo_cos), .lo_sin(lo_sin),
    .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
    .out_sample(out_sample), .out_valid(out_valid), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [1:0] exp_q[$];
  logic lo_rand = 1'b0;
  logic saw_wait = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // LO source: new random values shortly after each rising edge when enabled
  always @(posedge clk) begin
    #2;
    if (lo_rand) begin
      lo_cos = W'($urandom_range(0, MAXV));
      lo_sin = W'($urandom_range(0, MAXV));
    end
  end

  // Reference model: each accepted symbol yields SPS samples of +-cos +-sin,
  // computed from the LO present the cycle before the sample is seen.
  int k = 0;
  int pc = 0, ps = 0;
  logic q_force = 1'b0;
  logic cont = 1'b0;
  logic [1:0] cur = 2'b00;

  always @(negedge clk) begin
    int ie, qe, exp_s;
    logic qb;
    if (rst) begin
      exp_q.delete();
      k = 0;
      q_force = 1'b0;
      cont = 1'b0;
    end else begin
      if (cont) check("no_gap", int'(out_valid), 1);
      cont = 1'b0;
      if (out_valid) begin
        if (k == 0) begin
          check("sym_pending", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) cur = exp_q.pop_front();
          else cur = 2'b00;
        end
        qb = cur[0];
`ifdef QPSK_MOD_OFFSET_EN
        if (k < SPS / 2) qb = q_force;
        else q_force = cur[0];
`endif
        ie = cur[1] ? pc : -pc;
        qe = qb ? ps : -ps;
        exp_s = ie + qe;
        if (exp_s > MAXV) exp_s = MAXV;
        check("sample", int'(out_sample), exp_s);
        check("underrun", int'(underrun), (k == SPS - 1 && exp_q.size() == 0) ? 1 : 0);
        k++;
        if (k == SPS) begin
          k = 0;
          cont = (exp_q.size() > 0);
        end
      end else begin
        check("idle_sample", int'(out_sample), 0);
        check("idle_underrun", int'(underrun), 0);
        check("valid_mid_symbol", k, 0);
      end
    end
    pc = int'(lo_cos);
    ps = int'(lo_sin);
  end

  // Driver: called just after a falling edge; returns just after the next falling edge
  // following acceptance.
  task automatic send(input logic [1:0] b);
    int n = 0;
    in_bits  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n > 0) saw_wait = 1'b1;
    if (n >= 100) begin
      check("send_timeout", 0, 1);
    end else begin
      @(posedge clk);
      exp_q.push_back(b);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid || k != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", int'(n < 300), 1);
    @(negedge clk);
  endtask

  task automatic set_lo(input int c, input int s);
    lo_cos = W'(c);
    lo_sin = W'(s);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_sample", int'(out_sample), 0);
    end

    // single symbol, first sample two edges after acceptance
    set_lo(100, 50);
    send(2'b11);
    check("latency_e1", int'(out_valid), 0);
    @(negedge clk);
    check("latency_e2", int'(out_valid), 0);
    @(negedge clk);
    check("latency_e3", int'(out_valid), 1);
    wait_idle();

    send(2'b00);
    send(2'b01);
    wait_idle();

    // saturation corner and negative extreme
    set_lo(-256, -256);
    send(2'b00);
    wait_idle();
    send(2'b11);
    wait_idle();

    // three queued symbols with in_valid held
    set_lo(100, 50);
    saw_wait = 1'b0;
    send(2'b10);
    send(2'b01);
    send(2'b11);
    check("ready_dropped", int'(saw_wait), 1);
    wait_idle();

    // randomized symbols, LO and gaps
    lo_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send(2'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) == 0)
        repeat ($urandom_range(0, 2 * SPS)) @(negedge clk);
    end
    wait_idle();

    // reset in the middle of a symbol with a held successor
    send(2'b10);
    send(2'b01);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_sample", int'(out_sample), 0);
    check("midrst_underrun", int'(underrun), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(2'($urandom_range(0, 3)));
    wait_idle();

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qpsk_mod_stream.md
QPSK_MOD_STREAM -- requirements
Module: qpsk_mod_stream

Interface
- REQ-001: Parameter W, default 9: signed LO sample width in bits; W >= 4.
- REQ-002: Parameter SPS, default 8: output samples per symbol; SPS >= 2 and even.
- REQ-003: clk  input  1  sole clock; all state updates on rising edge.
- REQ-004: rst  input  1  reset, synchronous, active-high.
- REQ-005: lo_cos  input  W signed  cosine LO sample, supplied every cycle by the LO blocks.
- REQ-006: lo_sin  input  W signed  sine LO sample, supplied every cycle by the LO blocks.
- REQ-007: in_valid  input  1  symbol offered on in_bits.
- REQ-008: in_ready  output  1  block can accept a symbol this cycle.
- REQ-009: in_bits  input  2  symbol; bit 1 = I channel, bit 0 = Q channel.
- REQ-010: out_sample  output  W+1 signed  modulated sample, registered.
- REQ-011: out_valid  output  1  out_sample is a symbol sample this cycle.
- REQ-012: underrun  output  1  one-cycle pulse: symbol ended with no successor held.

Function
- REQ-013: A symbol transfers on a rising edge where in_valid and in_ready are both 1.
- REQ-014: One-entry holding register; in_ready = 1 exactly when the holding register is empty (combinational from state, never from in_valid).
- REQ-015: States IDLE and RUN; the sample counter runs 0..SPS-1 in RUN only.
- REQ-016: IDLE: out_valid = 0, out_sample = 0. A held symbol moves to the current-symbol register, counter = 0, state -> RUN.
- REQ-017: RUN: one output sample per cycle; counter increments; at SPS-1 the counter wraps to 0 and the held symbol, if present, becomes current in the same cycle (no gap between symbols).
- REQ-018: RUN at counter SPS-1 with holding register empty and no transfer that cycle: state -> IDLE, underrun = 1 for one cycle.
- REQ-019: A transfer during the final sample cycle of a symbol counts as held; no underrun, no gap.
- REQ-020: First out_valid sample appears 2 cycles after the accepting edge when starting from IDLE.
- REQ-021: Mapping: I=1 -> +lo_cos, I=0 -> -lo_cos; Q=1 -> +lo_sin, Q=0 -> -lo_sin; out_sample = I term + Q term.
- REQ-022: Arithmetic: both operands sign-extended to W+1 bits before negation; sum +2^W saturates to 2^W-1; all other sums are exact.
- REQ-023: out_sample is registered from the lo_cos/lo_sin values present on the cycle before it is output.
- REQ-024: Simultaneous holding-register drain and transfer in the same cycle are both honoured; no symbol is lost or duplicated.

Reset
- REQ-025: On a rst edge: state = IDLE, counter = 0, holding register empty, current I/Q = 0, out_sample = 0, out_valid = 0, underrun = 0; in_ready = 1 on the following cycle.
- REQ-026: rst during RUN aborts the symbol on that edge; any held symbol is discarded; rst takes priority over a transfer on the same edge.

Configuration
- REQ-027: Macro QPSK_MOD_OFFSET_EN defined: offset-QPSK. The Q bit of each symbol takes effect SPS/2 samples after its I bit. The Q bit in force before the first offset update is the reset value 0.
- REQ-028: QPSK_MOD_OFFSET_EN undefined: I and Q update together at the symbol boundary; no extra registers are built.

Verification (W=9, SPS=4)
- REQ-029: Release reset with in_valid=0 -> out_sample=0, out_valid=0, underrun=0, in_ready=1 indefinitely.
- REQ-030: lo_cos=100, lo_sin=50 constant; one symbol 2'b11 -> four samples of +150 with out_valid=1, underrun pulse on the last, then out_sample=0, out_valid=0.
- REQ-031: Back-to-back symbols 2'b00 then 2'b01 at the same LO values -> -150 x4 then -50 x4, out_valid continuously 1.
- REQ-032: lo_cos=lo_sin=-256, symbol 2'b00 -> +511 (saturated); lo_cos=lo_sin=-256, symbol 2'b11 -> -512.
- REQ-033: in_valid held 1 with three queued symbols -> in_ready drops while the holding register is full; all three are emitted in order, 12 samples, no gap.
- REQ-034: QPSK_MOD_OFFSET_EN defined, lo_cos=100, lo_sin=50; symbols 2'b11 then 2'b00 -> samples 50,50,150,150,-50,-50,-150,-150.
